// File: rtl/l0_feeder.sv
// Streams activation vectors from SRAM into the L0 buffer through a 2-entry skid,
// then issues the L0 drain burst and reports completion once L0 is empty.
module l0_feeder #(
  parameter int row    = 8,
  parameter int bw     = 4,
  parameter int addr_w = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [addr_w-1:0]     base_addr,
  input  logic [6:0]            num_vec,
  input  logic                  mode,
  output logic                  sram_cen,
  output logic                  sram_wen,
  output logic [addr_w-1:0]     sram_addr,
  input  logic [row*bw-1:0]     sram_dout,
  output logic [row*bw-1:0]     l0_in,
  output logic                  l0_wr,
  input  logic                  l0_full,
  input  logic                  l0_ready,
  output logic                  l0_rd,
  output logic                  l0_rd_version,
  output logic                  busy,
  output logic                  done
);

  localparam int dw = row * bw;
  localparam logic [6:0] max_vec = 7'd64;

  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, WAIT_EMPTY, DONE} state_t;

  state_t            state_reg, state_next;
  logic [addr_w-1:0] base_reg;
  logic [6:0]        n_reg;
  logic [6:0]        iss_reg;
  logic [6:0]        wcnt_reg;
  logic [6:0]        rcnt_reg;
  logic              mode_reg;
  logic              inflight_reg;
  logic [1:0]        skid_cnt_reg;
  logic [dw-1:0]     skid_q [2];

  logic              in_load;
  logic              skid_empty;
  logic              arrive;
  logic              issue;
  logic              pop;
  logic              push;
  logic [1:0]        push_idx;
  logic [2:0]        occ;
  logic [6:0]        wcnt_next;
  logic [6:0]        n_sat;

  assign in_load    = (state_reg == LOAD);
  assign skid_empty = (skid_cnt_reg == 2'd0);
  assign arrive     = in_load && inflight_reg;
  assign n_sat      = (num_vec > max_vec) ? max_vec : num_vec;

  // The skid head always goes first so arriving data never overtakes held data.
  assign l0_wr = in_load && !l0_full && (!skid_empty || inflight_reg);
  assign l0_in = !in_load ? '0 : (skid_empty ? sram_dout : skid_q[0]);

  assign pop      = l0_wr && !skid_empty;
  assign push     = arrive && !(l0_wr && skid_empty);
  assign push_idx = skid_cnt_reg - {1'b0, pop};

  // Occupancy after this cycle's write; only issue while a slot is guaranteed.
  assign occ   = {1'b0, skid_cnt_reg} + {2'b0, inflight_reg} - {2'b0, l0_wr};
  assign issue = in_load && (iss_reg < n_reg) && (occ < 3'd2);

  assign sram_cen  = !issue;
  assign sram_wen  = 1'b1;
  assign sram_addr = issue ? (base_reg + addr_w'(iss_reg)) : '0;

  assign wcnt_next = wcnt_reg + {6'd0, l0_wr};

  assign l0_rd         = (state_reg == DRAIN);
  assign l0_rd_version = mode_reg;
  assign busy          = (state_reg != IDLE);
  assign done          = (state_reg == DONE);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:       if (start) state_next = (n_sat == 7'd0) ? DONE : LOAD;
      LOAD:       if (wcnt_next == n_reg) state_next = DRAIN;
      DRAIN:      if (rcnt_reg == n_reg - 7'd1) state_next = WAIT_EMPTY;
      WAIT_EMPTY: if (l0_ready) state_next = DONE;
      DONE:       state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      base_reg     <= '0;
      n_reg        <= '0;
      mode_reg     <= 1'b0;
      iss_reg      <= '0;
      wcnt_reg     <= '0;
      rcnt_reg     <= '0;
      inflight_reg <= 1'b0;
      skid_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && start) begin
        base_reg     <= base_addr;
        n_reg        <= n_sat;
        mode_reg     <= mode;
        iss_reg      <= '0;
        wcnt_reg     <= '0;
        rcnt_reg     <= '0;
        inflight_reg <= 1'b0;
        skid_cnt_reg <= '0;
      end else begin
        if (issue) iss_reg <= iss_reg + 7'd1;
        inflight_reg <= issue;
        wcnt_reg     <= wcnt_next;
        skid_cnt_reg <= skid_cnt_reg + {1'b0, push} - {1'b0, pop};
        if (l0_rd) rcnt_reg <= rcnt_reg + 7'd1;
      end
    end
  end

  // Entry 0 is the head; a pop shifts entry 1 forward, a push lands behind the survivors.
  for (genvar gi = 0; gi < 2; gi++) begin : g_skid
    logic [dw-1:0] data_reg;
    always_ff @(posedge clk) begin
      if (reset) begin
        data_reg <= '0;
      end else if (push && push_idx == 2'(gi)) begin
        data_reg <= sram_dout;
      end else if (pop && gi == 0) begin
        data_reg <= skid_q[1];
      end
    end
    assign skid_q[gi] = data_reg;
  end

endmodule

// File: tb/tb_l0_feeder.sv
// Scoreboard bench for l0_feeder: SRAM and L0 models, expected reads/writes queued at issue time.
module tb_l0_feeder;
  localparam int AW = 11;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset, start, mode;
  logic [AW-1:0] base_addr;
  logic [6:0]    num_vec;
  logic          sram_cen, sram_wen;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_dout = '0;
  logic [DW-1:0] l0_in;
  logic          l0_wr, l0_full, l0_ready, l0_rd, l0_rd_version, busy, done;

  l0_feeder dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .num_vec(num_vec),
    .mode(mode), .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_dout(sram_dout), .l0_in(l0_in), .l0_wr(l0_wr), .l0_full(l0_full),
    .l0_ready(l0_ready), .l0_rd(l0_rd), .l0_rd_version(l0_rd_version), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] vec_of(input logic [AW-1:0] a);
    return {a, ~a, a[9:0]};
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  // SRAM model: one-cycle read latency
  always @(posedge clk) if (!sram_cen) sram_dout <= vec_of(sram_addr);

  // L0 model: occupancy plus a 7-cycle lane-skew tail after staggered reads
  int occ_m, tail_m;
  always @(posedge clk) begin
    if (reset) begin
      occ_m  <= 0;
      tail_m <= 0;
    end else begin
      occ_m <= occ_m + int'(l0_wr) - int'(l0_rd);
      if (l0_rd && l0_rd_version) tail_m <= 6;
      else if (tail_m > 0) tail_m <= tail_m - 1;
    end
  end
  assign l0_ready = (occ_m == 0) && (tail_m == 0);

  logic [AW-1:0] addr_q[$];
  logic [DW-1:0] data_q[$];
  int rd_cycles[$], wr_cycles[$], drain_cycles[$];
  int rsw = 0, max_rsw = 0, ver_bad = 0, full_wr_bad = 0;
  logic exp_mode = 1'b0;

  // Monitor: pops the scoreboard whenever the DUT reads SRAM or writes L0
  always @(negedge clk) begin
    if (l0_wr) begin
      wr_cycles.push_back(cyc);
      rsw = 0;
      if (l0_full) full_wr_bad++;
      if (data_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_write: got data %0h at cycle %0d, required no write", l0_in, cyc);
      end else begin
        chk("wr_data", l0_in, data_q.pop_front());
      end
    end
    if (!sram_cen) begin
      rd_cycles.push_back(cyc);
      rsw++;
      if (rsw > max_rsw) max_rsw = rsw;
      if (addr_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_read: got addr %0h at cycle %0d, required no read", sram_addr, cyc);
      end else begin
        chk("rd_addr", sram_addr, addr_q.pop_front());
      end
    end
    if (l0_rd) drain_cycles.push_back(cyc);
    if (busy && l0_rd_version != exp_mode) ver_bad++;
  end

  task automatic expect_vecs(input logic [AW-1:0] b, input int n_addr, input int n_data);
    for (int i = 0; i < n_addr; i++) addr_q.push_back(b + AW'(i));
    for (int i = 0; i < n_data; i++) data_q.push_back(vec_of(b + AW'(i)));
  endtask

  // Returns s = cycle index of the first LOAD cycle (start-edge + 1)
  task automatic launch(input logic [AW-1:0] b, input int n, input logic m, output int s);
    @(posedge clk);
    #1;
    rd_cycles.delete(); wr_cycles.delete(); drain_cycles.delete();
    rsw = 0; max_rsw = 0; ver_bad = 0; full_wr_bad = 0; exp_mode = m;
    base_addr = b; num_vec = 7'(n); mode = m; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    s = cyc;
  endtask

  task automatic wait_done(input int budget, output int dc);
    bit found = 0;
    dc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        dc = cyc;
        found = 1;
        break;
      end
    end
    if (!found) begin
      checks++;
      $display("FAIL done_timeout: got no done within %0d cycles, required done", budget);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic end_checks(input string tag);
    chk({tag, "_addr_left"}, addr_q.size(), 0);
    chk({tag, "_data_left"}, data_q.size(), 0);
    chk({tag, "_version"}, ver_bad, 0);
    chk({tag, "_wr_while_full"}, full_wr_bad, 0);
    addr_q.delete();
    data_q.delete();
  endtask

  task automatic reset_vals_check(input string tag);
    chk({tag, "_cen"}, sram_cen, 1);
    chk({tag, "_wen"}, sram_wen, 1);
    chk({tag, "_addr"}, sram_addr, 0);
    chk({tag, "_l0_wr"}, l0_wr, 0);
    chk({tag, "_l0_in"}, l0_in, 0);
    chk({tag, "_l0_rd"}, l0_rd, 0);
    chk({tag, "_version"}, l0_rd_version, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int s, dc;
    reset = 1'b1; start = 1'b0; base_addr = '0; num_vec = '0; mode = 1'b0; l0_full = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    reset_vals_check("por");

    // Basic load N=4, base 0x010
    expect_vecs(11'h010, 4, 4);
    launch(11'h010, 4, 1'b0, s);
    wait_done(100, dc);
    chk("t1_nreads", rd_cycles.size(), 4);
    chk("t1_first_rd", rd_cycles[0], s);
    chk("t1_last_rd", rd_cycles[3], s + 3);
    chk("t1_first_wr", wr_cycles[0], s + 1);
    chk("t1_last_wr", wr_cycles[3], s + 4);
    chk("t1_ndrain", drain_cycles.size(), 4);
    chk("t1_first_drain", drain_cycles[0], s + 5);
    chk("t1_last_drain", drain_cycles[3], s + 8);
    chk("t1_done_cyc", dc, s + 10);
    end_checks("t1");

    // Backpressure N=8, l0_full for 5 cycles from the 3rd write
    expect_vecs(11'h100, 8, 8);
    launch(11'h100, 8, 1'b0, s);
    repeat (3) @(posedge clk);
    #1 l0_full = 1'b1;
    repeat (5) @(posedge clk);
    #1 l0_full = 1'b0;
    wait_done(200, dc);
    chk("t2_nwrites", wr_cycles.size(), 8);
    chk("t2_resume_wr", wr_cycles[2], s + 8);
    chk("t2_reads_ahead_le2", (max_rsw <= 2) ? 1 : 0, 1);
    chk("t2_nreads", rd_cycles.size(), 8);
    end_checks("t2");

    // Staggered mode N=16
    expect_vecs(11'h300, 16, 16);
    launch(11'h300, 16, 1'b1, s);
    wait_done(300, dc);
    chk("t3_ndrain", drain_cycles.size(), 16);
    chk("t3_last_drain", drain_cycles[15], s + 32);
    chk("t3_done_cyc", dc, s + 40);
    end_checks("t3");

    // N=0
    launch(11'h050, 0, 1'b0, s);
    wait_done(10, dc);
    chk("t4_done_cyc", dc, s);
    chk("t4_nreads", rd_cycles.size(), 0);
    chk("t4_nwrites", wr_cycles.size(), 0);
    end_checks("t4");

    // N=100 saturates to 64
    expect_vecs(11'h400, 64, 64);
    launch(11'h400, 100, 1'b0, s);
    wait_done(400, dc);
    chk("t5_nwrites", wr_cycles.size(), 64);
    chk("t5_ndrain", drain_cycles.size(), 64);
    end_checks("t5");

    // Address wrap from 0x7FE
    expect_vecs(11'h7FE, 4, 4);
    launch(11'h7FE, 4, 1'b0, s);
    wait_done(100, dc);
    chk("t6_nreads", rd_cycles.size(), 4);
    end_checks("t6");

    // Reset mid-LOAD after 3 writes with the 4th read in flight
    expect_vecs(11'h040, 4, 3);
    launch(11'h040, 8, 1'b0, s);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    reset_vals_check("mid");
    repeat (3) @(negedge clk);
    chk("t7_nwrites", wr_cycles.size(), 3);
    end_checks("t7");
    expect_vecs(11'h200, 3, 3);
    launch(11'h200, 3, 1'b0, s);
    wait_done(100, dc);
    chk("t7b_nwrites", wr_cycles.size(), 3);
    chk("t7b_first_rd", rd_cycles[0], s);
    end_checks("t7b");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/l0_feeder.md
# l0_feeder

Loader/drain controller that sits directly upstream of the L0 input buffer. It streams `num_vec` activation vectors from the activation SRAM into L0, absorbing L0 backpressure with a 2-entry skid buffer. It then issues the read burst that drains L0 into the PE array, in either broadcast or staggered (wavefront) read mode. It signals completion once L0 reports empty.

## Interface
- `row`, 8: number of lanes per vector; matches L0 `row`.
- `bw`, 4: bits per lane; matches L0 `bw`.
- `addr_w`, 11: SRAM address width.
- Clock and reset: one clock `clk`; reset `reset` is synchronous and active-high.
- `clk` input 1: sole clock; all state updates on posedge.
- `reset` input 1: synchronous, active-high; returns the block to IDLE.
- `start` input 1: one-cycle request; sampled only in IDLE.
- `base_addr` input addr_w: first SRAM address; latched on accepted `start`.
- `num_vec` input 7: vectors to load; latched on `start`. Values 65..127 saturate to 64 (L0 depth). 0 is legal.
- `mode` input 1: L0 read mode; latched on `start`. 0 = broadcast, 1 = staggered.
- `sram_cen` output 1: SRAM chip enable, active-low.
- `sram_wen` output 1: SRAM write enable, active-low; constant 1.
- `sram_addr` output addr_w: SRAM read address.
- `sram_dout` input row*bw: SRAM read data, valid the cycle after `sram_cen`=0.
- `l0_in` output row*bw: write data to L0.
- `l0_wr` output 1: L0 write strobe.
- `l0_full` input 1: L0 any-FIFO-full.
- `l0_ready` input 1: L0 all-FIFOs-empty.
- `l0_rd` output 1: L0 read request.
- `l0_rd_version` output 1: latched `mode`, held stable from LOAD through DONE.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse in DONE.

## Operation
- FSM states: IDLE, LOAD, DRAIN, WAIT_EMPTY, DONE.
- IDLE → LOAD on `start`. If the latched count is 0, IDLE → DONE instead.
- LOAD maintains the following:
  - Issue counter `iss` (0..N). Each issue drives `sram_cen`=0 with `sram_addr` = base + `iss`, address wrapping mod 2^addr_w.
  - In-flight flag: one read is outstanding at a time.
  - Skid FIFO: 2 entries.
  - Write counter `wcnt`.
- Write path (combinational):
  - `l0_wr` = LOAD and !`l0_full` and (skid non-empty or in-flight data arriving).
  - `l0_in` = skid head if the skid is non-empty, else `sram_dout`. Order is strictly preserved.
- Arriving data that is not written this cycle is pushed into the skid.
- Issue rule: issue when `iss` < N and (skid_cnt + inflight − l0_wr) < 2. Skid overflow is therefore impossible.
- LOAD → DRAIN when `wcnt` reaches N (takes effect the cycle after the last write).
- DRAIN: `l0_rd`=1 for exactly N consecutive cycles, then → WAIT_EMPTY.
- WAIT_EMPTY → DONE when `l0_ready`=1. In staggered mode this covers the lane-skew tail of row−1 cycles.
- DONE → IDLE the following cycle; `done`=1 only in DONE.
- `start` in any non-IDLE state is ignored.

## Timing
- Reset values:
  - `sram_cen`=1, `sram_wen`=1, `sram_addr`=0.
  - `l0_wr`=0, `l0_in`=0, `l0_rd`=0.
  - `l0_rd_version`=0, `busy`=0, `done`=0.
  - Skid empty, counters 0, in-flight cleared.
- `start` is sampled at edge t. LOAD occupies cycles t+1 onward, and the first read is issued in cycle t+1.
- SRAM read latency is 1 cycle, so data for an issue in cycle c is available in cycle c+1.
- With no backpressure: one write per cycle, writes in cycles t+2..t+N+1, DRAIN in cycles t+N+2..t+2N+1.
- `l0_full` asserted: `l0_wr`=0 in the same cycle. At most 2 vectors are held (skid); issue stalls until space frees.
- `l0_full` deasserts: a write occurs in that same cycle from the skid head.
- Reset mid-operation: the next cycle is IDLE with reset values. A read still in flight is discarded, and its `sram_dout` is ignored.
- `l0_ready` is ignored outside WAIT_EMPTY.

## Test plan
- Basic load, N=4, base 0x010, mode 0, `l0_full`=0:
  - Addresses 0x010..0x013 issued in cycles t+1..t+4.
  - Writes in cycles t+2..t+5, in order.
  - `l0_rd`=1 in cycles t+6..t+9.
  - `done` pulse one cycle after `l0_ready`=1.
- Backpressure, N=8, with `l0_full` forced high for 5 cycles starting at the 3rd write:
  - Exactly 8 writes occur, no duplicate or dropped vector, order intact.
  - `sram_cen` is low for at most 2 reads beyond the last write before the stall.
- Staggered mode, N=16, mode 1:
  - `l0_rd_version`=1 from LOAD through DONE.
  - `l0_rd` high for 16 cycles.
  - DONE is not entered until the bench's L0 model asserts `l0_ready` 7 cycles after the last read.
- Edge counts:
  - N=0: `done` at t+1, no SRAM access, no `l0_wr`.
  - N=100: saturates to 64 writes and 64 read cycles.
  - base 0x7FE with N=4: addresses 0x7FE, 0x7FF, 0x000, 0x001.
- Reset injected mid-LOAD (after 3 writes, with 1 read in flight): next cycle shows all outputs at reset values. The data arriving after reset produces no `l0_wr`. A new `start` then runs cleanly from the new base.
